// File: rtl/mips_pkg.sv
// Shared MIPS fetch/decode constants: word width, jump opcodes and the
// instruction word presented to decode when nothing is buffered.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [5:0] OPC_J   = 6'b000010;
    localparam logic [5:0] OPC_JAL = 6'b000011;

    localparam logic [WORD_W-1:0] NOP_DEFAULT = 32'h0000_0000;

    function automatic logic is_jump(input logic [WORD_W-1:0] instr);
        return (instr[31:26] == OPC_J) || (instr[31:26] == OPC_JAL);
    endfunction

endpackage

// File: rtl/instr_queue2.sv
// Two-entry in-order queue of {PC+4, instruction} with 1-bit pointers.
// A clear empties it in one cycle and takes priority over push and pop.
module instr_queue2
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [WORD_W-1:0] push_pc4,
    input  logic [WORD_W-1:0] push_instr,
    output logic [WORD_W-1:0] head_pc4,
    output logic [WORD_W-1:0] head_instr,
    output logic [1:0]        count
);

    logic [WORD_W-1:0] pc4_mem   [2];
    logic [WORD_W-1:0] instr_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    // The caller guarantees push only below full and pop only when non-empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count        <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            pc4_mem[0]   <= '0;
            pc4_mem[1]   <= '0;
            instr_mem[0] <= '0;
            instr_mem[1] <= '0;
        end else if (clear) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                pc4_mem[wr_ptr]   <= push_pc4;
                instr_mem[wr_ptr] <= push_instr;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    assign head_pc4   = pc4_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/decode_instr_buffer.sv
// Fetch-to-decode instruction buffer: queues up to two fetched words, issues
// them in order under stall/flush, and redirects fetch when a j/jal issues.
module decode_instr_buffer
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [WORD_W-1:0] PCAdder_in,
    input  logic [WORD_W-1:0] Instr_in,
    input  logic              Fetch_valid,
    input  logic              Decode_stall,
    input  logic              Flush,
    output logic              PCWrite_out,
    output logic [WORD_W-1:0] Instr_out,
    output logic [WORD_W-1:0] PCAdder_out,
    output logic              Valid_out,
    output logic              JumpControl_out,
    output logic [WORD_W-1:0] JumpTarget_out
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [1:0]        count;
    logic [WORD_W-1:0] head_pc4;
    logic [WORD_W-1:0] head_instr;
    logic              push;
    logic              pop;
    logic              jump_pop;
    logic              clear;

    instr_queue2 u_queue (
        .clk        (Clk),
        .rst        (Rst),
        .push       (push),
        .pop        (pop),
        .clear      (clear),
        .push_pc4   (PCAdder_in),
        .push_instr (Instr_in),
        .head_pc4   (head_pc4),
        .head_instr (head_instr),
        .count      (count)
    );

    // No bypass at full: fetch is held off by PCWrite_out, which depends on count alone.
    always_comb begin
        Valid_out   = (count != 2'd0);
        PCWrite_out = (count < FULL);
        Instr_out   = Valid_out ? head_instr : NOP_WORD;
        PCAdder_out = Valid_out ? head_pc4   : '0;

        pop      = Valid_out && !Decode_stall && !Flush;
        jump_pop = pop && is_jump(Instr_out);
        push     = Fetch_valid && PCWrite_out && !Flush && !jump_pop;
        clear    = Flush || jump_pop;

        JumpControl_out = jump_pop;
        JumpTarget_out  = {PCAdder_out[31:28], Instr_out[25:0], 2'b00};
    end

endmodule

// File: tb/tb_decode_instr_buffer.sv
// Directed bench for decode_instr_buffer: a scoreboard queue of expected
// entries is filled on accepted fetches and drained as decode takes them.
module tb_decode_instr_buffer;

    logic        Clk;
    logic        Rst;
    logic [31:0] PCAdder_in;
    logic [31:0] Instr_in;
    logic        Fetch_valid;
    logic        Decode_stall;
    logic        Flush;
    logic        PCWrite_out;
    logic [31:0] Instr_out;
    logic [31:0] PCAdder_out;
    logic        Valid_out;
    logic        JumpControl_out;
    logic [31:0] JumpTarget_out;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    decode_instr_buffer dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .PCAdder_in      (PCAdder_in),
        .Instr_in        (Instr_in),
        .Fetch_valid     (Fetch_valid),
        .Decode_stall    (Decode_stall),
        .Flush           (Flush),
        .PCWrite_out     (PCWrite_out),
        .Instr_out       (Instr_out),
        .PCAdder_out     (PCAdder_out),
        .Valid_out       (Valid_out),
        .JumpControl_out (JumpControl_out),
        .JumpTarget_out  (JumpTarget_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"},  32'(Valid_out),       32'd0);
        check({tag, "_instr"},  Instr_out,            32'h0000_0000);
        check({tag, "_pc4"},    PCAdder_out,          32'h0000_0000);
        check({tag, "_pcwr"},   32'(PCWrite_out),     32'd1);
        check({tag, "_jctl"},   32'(JumpControl_out), 32'd0);
        check({tag, "_jtgt"},   JumpTarget_out,       32'h0000_0000);
    endtask

    // One clock cycle: drive inputs, check outputs against the scoreboard, advance.
    task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                                 input logic st, input logic fl);
        logic mvalid, mpop, mjump, mpush;
        exp_t e;
        Fetch_valid  = fv;
        PCAdder_in   = pc;
        Instr_in     = ins;
        Decode_stall = st;
        Flush        = fl;
        #1;
        mvalid = (sb.size() != 0);
        check("pcwrite", 32'(PCWrite_out), 32'(sb.size() < 2));
        check("valid",   32'(Valid_out),   32'(mvalid));
        if (mvalid) begin
            check("head_instr", Instr_out,      sb[0].ins);
            check("head_pc4",   PCAdder_out,    sb[0].pc);
            check("jump_tgt",   JumpTarget_out, {sb[0].pc[31:28], sb[0].ins[25:0], 2'b00});
        end else begin
            check("empty_instr", Instr_out,   32'h0000_0000);
            check("empty_pc4",   PCAdder_out, 32'h0000_0000);
        end
        mpop  = mvalid && !st && !fl;
        mjump = mpop && (sb[0].ins[31:26] == 6'b000010 || sb[0].ins[31:26] == 6'b000011);
        check("jump_ctl", 32'(JumpControl_out), 32'(mjump));
        mpush = fv && (sb.size() < 2) && !fl && !mjump;
        if (fl || mjump) begin
            sb.delete();
        end else if (mpop) begin
            void'(sb.pop_front());
        end
        if (mpush) begin
            e.pc  = pc;
            e.ins = ins;
            sb.push_back(e);
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst          = 1'b1;
        Fetch_valid  = 1'b0;
        PCAdder_in   = '0;
        Instr_in     = '0;
        Decode_stall = 1'b0;
        Flush        = 1'b0;
        #3;
        check_reset_values("reset");
        #9 Rst = 1'b0;
        @(posedge Clk);
        #1;

        $display("[TB] three pushes while decode stalls");
        applyStimulus(1'b1, 32'h4, 32'h2001_0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h2001_0002, 1'b1, 1'b0);
        check("full_pcwrite", 32'(PCWrite_out), 32'd0);
        applyStimulus(1'b1, 32'hC, 32'h2001_0003, 1'b1, 1'b0);
        check("held_head_pc4", PCAdder_out, 32'h4);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("[TB] streaming five instructions without stall");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 32'(4 * k), 32'h2000_0100 + 32'(k), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("[TB] jump at head with a younger entry buffered");
        applyStimulus(1'b1, 32'h4000_0004, 32'h0800_0010, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h4000_0008, 32'h2002_0002, 1'b1, 1'b0);
        Fetch_valid = 1'b1; PCAdder_in = 32'h4000_000C; Instr_in = 32'h2002_0003;
        Decode_stall = 1'b0; Flush = 1'b0;
        #1;
        check("jump_issue_ctl", 32'(JumpControl_out), 32'd1);
        check("jump_issue_tgt", JumpTarget_out, 32'h4000_0040);
        applyStimulus(1'b1, 32'h4000_000C, 32'h2002_0003, 1'b0, 1'b0);
        check("after_jump_valid", 32'(Valid_out), 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("[TB] jal alone at head with a same-cycle fetch");
        applyStimulus(1'b1, 32'h1000_0010, 32'h0C00_0100, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h1000_0014, 32'h2003_0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("[TB] flush beats a jump at head");
        applyStimulus(1'b1, 32'h0000_0104, 32'h0800_0020, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_0108, 32'h2004_0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_010C, 32'h2004_0002, 1'b0, 1'b1);
        check("after_flush_instr", Instr_out, 32'h0000_0000);
        applyStimulus(1'b1, 32'h0000_0200, 32'h2004_0003, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("[TB] asynchronous reset while full");
        applyStimulus(1'b1, 32'h0000_0304, 32'h2005_0001, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0000_0308, 32'h2005_0002, 1'b1, 1'b0);
        Fetch_valid = 1'b0;
        #2 Rst = 1'b1;
        #1;
        check_reset_values("midreset");
        sb.delete();
        #2 Rst = 1'b0;
        @(posedge Clk);
        #1;
        applyStimulus(1'b1, 32'h0000_0404, 32'h2006_0001, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_instr_buffer.md
# decode_instr_buffer

Receiving end of the fetch-to-decode interface: accepts PC+4 and instruction words from the fetch stage, buffers up to two of them, and presents them in order to decode under a stall/flush discipline. It also closes the loop back to fetch. It drives the PC-write enable when it has space, and it drives the jump redirect (control plus target) when a `j`/`jal` is issued into decode.

## Interface
Parameters:
- `DEPTH`, 2: buffer entries; fixed at 2 in this revision, pointers are 1 bit.
- `NOP_WORD`, 32'h0000_0000: value driven on `Instr_out` when no entry is valid.

Ports:
- `Clk`  in  1  system clock, all state on rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `PCAdder_in`  in  32  PC+4 of the fetched instruction.
- `Instr_in`  in  32  fetched instruction word.
- `Fetch_valid`  in  1  fetch presents a new instruction this cycle.
- `Decode_stall`  in  1  decode cannot accept the head entry this cycle.
- `Flush`  in  1  taken branch resolved downstream; discard everything buffered.
- `PCWrite_out`  out  1  fetch may advance its PC.
- `Instr_out`  out  32  head instruction to decode.
- `PCAdder_out`  out  32  head PC+4 to decode.
- `Valid_out`  out  1  head entry is valid.
- `JumpControl_out`  out  1  redirect fetch to `JumpTarget_out` this cycle.
- `JumpTarget_out`  out  32  jump target address.

## Operation
- State:
  - two entries of {PC+4, instr}
  - `wr_ptr`, `rd_ptr` (1 bit each, wrap 1→0)
  - `count` (0..2)
- `PCWrite_out = (count < 2)`. Derived from registered state only, with no input-to-output path.
- Push when `Fetch_valid && count<2 && !Flush && !jump_pop`. Writes the entry at `wr_ptr` and advances `wr_ptr`.
- Pop when `Valid_out && !Decode_stall && !Flush`. Advances `rd_ptr`.
- There is no bypass: a push at `count==2` is refused even if a pop occurs the same cycle. Fetch must hold, guaranteed by `PCWrite_out=0`.
- Push and pop in the same cycle leave `count` unchanged.
- `Valid_out = (count != 0)`. While empty, `Instr_out = NOP_WORD` and `PCAdder_out = 0`.
- Jump detection:
  - `jump_pop` = pop && head opcode[31:26] ∈ {6'b000010 (j), 6'b000011 (jal)}.
  - `JumpControl_out = jump_pop`.
  - `JumpTarget_out = {PCAdder_out[31:28], Instr_out[25:0], 2'b00}`, valid whenever `Valid_out`.
- On `jump_pop`:
  - The jump itself is delivered to decode.
  - All younger buffered entries are discarded, so `count` is 0 next cycle.
  - Any same-cycle push is refused; there is no delay slot.
- On `Flush`:
  - `count`, `wr_ptr` and `rd_ptr` are 0 next cycle.
  - No push, no pop, and `JumpControl_out` is forced to 0.
  - `Flush` has priority over stall, push, pop and jump.
- Stalled head: while `Decode_stall` is high the head outputs hold stable and `JumpControl_out` stays 0.

## Timing
- Reset values:
  - `count=0`, both pointers 0.
  - `Valid_out=0`, `Instr_out=NOP_WORD`, `PCAdder_out=0`.
  - `JumpControl_out=0`, `JumpTarget_out={4'b0,NOP_WORD[25:0],2'b00}`.
  - `PCWrite_out=1`.
- Reset takes effect immediately and asynchronously, mid-operation included. All buffered entries are lost.
- Push-to-`Valid_out` latency is 1 cycle: an entry pushed at edge N is visible after edge N.
- Throughput is 1 instruction per cycle when decode never stalls.
- `JumpControl_out` and `JumpTarget_out` are combinational from head state and `Decode_stall`/`Flush`. They are asserted in the issue cycle, and fetch samples them at the next edge.
- `PCWrite_out` falls the cycle after the second push and rises the cycle after a pop from full.

## Structure
- Shared package `mips_pkg`:
  - opcode constants `OPC_J`, `OPC_JAL`.
  - `NOP_WORD` default.
  - 32-bit word width constant.
- One natural sub-module: `instr_queue2`, the 2-entry pointer/count storage with push/pop/clear. Jump detection and target formation stay in the top.

## Test plan
- Reset, then 3 pushes of (PC+4=0x4, 0x8, 0xC) with `Decode_stall=1`:
  - `count` saturates at 2 and `PCWrite_out=0` after the second push.
  - The third push is refused.
  - Head holds PCAdder 0x4.
- Continuous fetch with no stall, 5 instructions → `Valid_out` rises 1 cycle after the first push, and decode sees 0x4,0x8,… on consecutive cycles.
- Head `j` = 0x0800_0010 with PCAdder 0x4000_0004 and one younger entry buffered:
  - `JumpControl_out=1` for exactly 1 cycle.
  - `JumpTarget_out=0x4000_0040`.
  - `count` is 0 next cycle and the same-cycle push is refused.
- `Flush` asserted with `count=2`, `Fetch_valid=1` and a jump at head → no `JumpControl_out`, and `Valid_out=0`/`Instr_out=0` next cycle.
- `Rst` asserted mid-cycle with `count=2` → outputs return to reset values immediately, without waiting for a clock edge.
